// File: rtl/rs_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rs_mem_pkg                                                 |
// | Description : Shared defaults and record types for the memory            |
// |               reservation station (load/store buffer).                   |
// | Contents    : RS_DEPTH / RS_TAG_W defaults, ctl_t (per-entry control),   |
// |               operand_t, entry_t (complete entry record), head_ready().  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package rs_mem_pkg;

   localparam int RS_DEPTH = 4;
   localparam int RS_TAG_W = 4;
   localparam int WORD_W   = 32;
   localparam int BHW_W    = 3;

   // Control part of an entry; the operand parts live in rs_mem_operand.
   typedef struct packed {
      logic              valid;
      logic              mem_w;
      logic [BHW_W-1:0]  bhw;
      logic [WORD_W-1:0] imm;
   } ctl_t;

   typedef struct packed {
      logic                rdy;
      logic [RS_TAG_W-1:0] tag;
      logic [WORD_W-1:0]   data;
   } operand_t;

   // Complete logical view of one buffer entry.
   typedef struct packed {
      ctl_t                ctl;
      logic [RS_TAG_W-1:0] index;
      operand_t            rs1;
      operand_t            rs2;
   } entry_t;

   // Loads never read rs2, so only stores wait on it.
   function automatic logic head_ready(input ctl_t c, input logic rs1_rdy,
                                       input logic rs2_rdy);
      return c.valid & rs1_rdy & (rs2_rdy | ~c.mem_w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rs_mem_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rs_mem_if                                                  |
// | Description : Dispatch, CDB and memory-FU bus of the memory reservation  |
// |               station.                                                   |
// | Modports    : slave  - the reservation station (consumes dispatch/CDB,   |
// |                        drives full and fu_*)                             |
// |               master - the surrounding pipeline                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface rs_mem_if
   import rs_mem_pkg::*;
#(
   parameter int TAG_W = RS_TAG_W
);
   // dispatch side
   logic              iss_valid;
   logic              iss_mem_w;
   logic [BHW_W-1:0]  iss_bhw;
   logic [WORD_W-1:0] iss_imm;
   logic              iss_rs1_rdy;
   logic              iss_rs2_rdy;
   logic [TAG_W-1:0]  iss_rs1_tag;
   logic [TAG_W-1:0]  iss_rs2_tag;
   logic [WORD_W-1:0] iss_rs1_data;
   logic [WORD_W-1:0] iss_rs2_data;
   logic [TAG_W-1:0]  iss_index;
   logic              full;
   // common data bus
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [WORD_W-1:0] cdb_data;
   // memory functional unit
   logic              fu_idle;
   logic              fu_en;
   logic              fu_mem_w;
   logic [BHW_W-1:0]  fu_bhw;
   logic [WORD_W-1:0] fu_rs1_data;
   logic [WORD_W-1:0] fu_rs2_data;
   logic [WORD_W-1:0] fu_imm;
   logic [TAG_W-1:0]  fu_index;

   modport slave (
      input  iss_valid, iss_mem_w, iss_bhw, iss_imm, iss_rs1_rdy, iss_rs2_rdy,
             iss_rs1_tag, iss_rs2_tag, iss_rs1_data, iss_rs2_data, iss_index,
             cdb_valid, cdb_tag, cdb_data, fu_idle,
      output full, fu_en, fu_mem_w, fu_bhw, fu_rs1_data, fu_rs2_data, fu_imm,
             fu_index
   );

   modport master (
      output iss_valid, iss_mem_w, iss_bhw, iss_imm, iss_rs1_rdy, iss_rs2_rdy,
             iss_rs1_tag, iss_rs2_tag, iss_rs1_data, iss_rs2_data, iss_index,
             cdb_valid, cdb_tag, cdb_data, fu_idle,
      input  full, fu_en, fu_mem_w, fu_bhw, fu_rs1_data, fu_rs2_data, fu_imm,
             fu_index
   );

endinterface
`default_nettype wire

// File: rtl/rs_mem_operand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rs_mem_operand                                             |
// | Description : One source operand {rdy, tag, data} of a buffer entry,     |
// |               with CDB snooping and dispatch-time CDB bypass.            |
// | Ports       : clk, rst        clock / synchronous active-high reset      |
// |               i_entry_valid   owning entry holds a live op               |
// |               i_load          entry is being written by dispatch         |
// |               i_ld_*          operand as presented by dispatch           |
// |               i_cdb_*         common data bus broadcast                  |
// |               o_rdy, o_data   registered operand state                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module rs_mem_operand
   import rs_mem_pkg::*;
#(
   parameter int TAG_W = RS_TAG_W
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_entry_valid,
   input  wire logic              i_load,
   input  wire logic              i_ld_rdy,
   input  wire logic [TAG_W-1:0]  i_ld_tag,
   input  wire logic [WORD_W-1:0] i_ld_data,
   input  wire logic              i_cdb_valid,
   input  wire logic [TAG_W-1:0]  i_cdb_tag,
   input  wire logic [WORD_W-1:0] i_cdb_data,
   output logic                   o_rdy,
   output logic [WORD_W-1:0]      o_data
);

   logic              rdy_q,  rdy_d;
   logic [TAG_W-1:0]  tag_q,  tag_d;
   logic [WORD_W-1:0] data_q, data_d;

   always_comb begin
      rdy_d  = rdy_q;
      tag_d  = tag_q;
      data_d = data_q;
      if (i_load) begin
         tag_d = i_ld_tag;
         if (i_ld_rdy) begin
            rdy_d  = 1'b1;
            data_d = i_ld_data;
         end else if (i_cdb_valid && (i_cdb_tag == i_ld_tag)) begin
            // Producer broadcasts on the very edge the consumer enters.
            rdy_d  = 1'b1;
            data_d = i_cdb_data;
         end else begin
            rdy_d  = 1'b0;
            data_d = '0;
         end
      end else if (i_entry_valid && !rdy_q && i_cdb_valid &&
                   (i_cdb_tag == tag_q)) begin
         rdy_d  = 1'b1;
         data_d = i_cdb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q  <= 1'b0;
         tag_q  <= '0;
         data_q <= '0;
      end else begin
         rdy_q  <= rdy_d;
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

   assign o_rdy  = rdy_q;
   assign o_data = data_q;

endmodule
`default_nettype wire

// File: rtl/rs_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rs_mem                                                     |
// | Description : In-order load/store reservation station. Ops enter at the  |
// |               tail, wait for operands via CDB snooping and leave from    |
// |               the head only, preserving memory ordering.                 |
// | Ports       : clk   rising-edge clock                                    |
// |               rst   synchronous active-high reset                        |
// |               bus   rs_mem_if.slave: dispatch (iss_*, full), CDB (cdb_*),|
// |                     memory FU (fu_idle in, fu_en / fu_* out)             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module rs_mem
   import rs_mem_pkg::*;
#(
   parameter int DEPTH = RS_DEPTH,
   parameter int TAG_W = RS_TAG_W
) (
   input wire logic clk,
   input wire logic rst,
   rs_mem_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] C_PTR_ONE    = PTR_W'(1);

   ctl_t              ctl_q   [DEPTH];
   ctl_t              ctl_d   [DEPTH];
   logic [TAG_W-1:0]  index_q [DEPTH];
   logic [TAG_W-1:0]  index_d [DEPTH];
   logic [PTR_W-1:0]  head_q,  head_d;
   logic [PTR_W-1:0]  tail_q,  tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [DEPTH-1:0]  w_rs1_rdy;
   logic [DEPTH-1:0]  w_rs2_rdy;
   logic [WORD_W-1:0] w_rs1_data [DEPTH];
   logic [WORD_W-1:0] w_rs2_data [DEPTH];

   logic              w_full;
   logic              w_enq;
   logic              w_deq;
   ctl_t              w_head;

   // Full looks only at registered occupancy: a dequeue in this cycle does
   // not make room for this cycle's dispatch.
   assign w_full = (count_q == C_FULL_COUNT);
   assign w_enq  = bus.iss_valid & ~w_full;
   assign w_head = ctl_q[head_q];
   assign w_deq  = head_ready(w_head, w_rs1_rdy[head_q], w_rs2_rdy[head_q]) &
                   bus.fu_idle;

   // FU presentation: head fields while the head is live, zero otherwise.
   always_comb begin
      bus.full        = w_full;
      bus.fu_en       = w_deq;
      bus.fu_mem_w    = 1'b0;
      bus.fu_bhw      = '0;
      bus.fu_imm      = '0;
      bus.fu_index    = '0;
      bus.fu_rs1_data = '0;
      bus.fu_rs2_data = '0;
      if (w_head.valid) begin
         bus.fu_mem_w    = w_head.mem_w;
         bus.fu_bhw      = w_head.bhw;
         bus.fu_imm      = w_head.imm;
         bus.fu_index    = index_q[head_q];
         bus.fu_rs1_data = w_rs1_data[head_q];
         bus.fu_rs2_data = w_rs2_data[head_q];
      end
   end

   always_comb begin
      ctl_d   = ctl_q;
      index_d = index_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (w_deq) begin
         ctl_d[head_q].valid = 1'b0;
         head_d              = head_q + C_PTR_ONE;
      end
      if (w_enq) begin
         ctl_d[tail_q].valid = 1'b1;
         ctl_d[tail_q].mem_w = bus.iss_mem_w;
         ctl_d[tail_q].bhw   = bus.iss_bhw;
         ctl_d[tail_q].imm   = bus.iss_imm;
         index_d[tail_q]     = bus.iss_index;
         tail_d              = tail_q + C_PTR_ONE;
      end
      count_d = count_q + CNT_W'(w_enq) - CNT_W'(w_deq);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctl_q[i]   <= '0;
            index_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ctl_q[i]   <= ctl_d[i];
            index_q[i] <= index_d[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      logic w_load;
      assign w_load = w_enq & (tail_q == PTR_W'(g));

      rs_mem_operand #(.TAG_W(TAG_W)) u_rs1 (
         .clk           (clk),
         .rst           (rst),
         .i_entry_valid (ctl_q[g].valid),
         .i_load        (w_load),
         .i_ld_rdy      (bus.iss_rs1_rdy),
         .i_ld_tag      (bus.iss_rs1_tag),
         .i_ld_data     (bus.iss_rs1_data),
         .i_cdb_valid   (bus.cdb_valid),
         .i_cdb_tag     (bus.cdb_tag),
         .i_cdb_data    (bus.cdb_data),
         .o_rdy         (w_rs1_rdy[g]),
         .o_data        (w_rs1_data[g])
      );

      rs_mem_operand #(.TAG_W(TAG_W)) u_rs2 (
         .clk           (clk),
         .rst           (rst),
         .i_entry_valid (ctl_q[g].valid),
         .i_load        (w_load),
         .i_ld_rdy      (bus.iss_rs2_rdy),
         .i_ld_tag      (bus.iss_rs2_tag),
         .i_ld_data     (bus.iss_rs2_data),
         .i_cdb_valid   (bus.cdb_valid),
         .i_cdb_tag     (bus.cdb_tag),
         .i_cdb_data    (bus.cdb_data),
         .o_rdy         (w_rs2_rdy[g]),
         .o_data        (w_rs2_data[g])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_rs_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rs_mem                                                  |
// | Description : Self-checking bench for rs_mem. Accepted dispatches push   |
// |               their expected FU presentation into a scoreboard queue; a  |
// |               negedge monitor pops and compares on every fu_en.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_rs_mem;
   import rs_mem_pkg::*;

   localparam int TW = 4;

   typedef struct {
      logic          mem_w;
      logic [2:0]    bhw;
      logic [31:0]   imm;
      logic          rs1_rdy;
      logic [TW-1:0] rs1_tag;
      logic [31:0]   rs1_data;
      logic          rs2_rdy;
      logic [TW-1:0] rs2_tag;
      logic [31:0]   rs2_data;
      logic [TW-1:0] index;
      logic [31:0]   exp_rs1;
      logic [31:0]   exp_rs2;
   } op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   op_t  sb [$];
   op_t  mon_e;
   op_t  vec [6];
   op_t  o;

   rs_mem_if #(.TAG_W(TW)) bus ();

   rs_mem #(.DEPTH(4), .TAG_W(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic op_t mk(input logic mw, input logic [2:0] b,
                              input logic [31:0] im, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [TW-1:0] ix);
      op_t r;
      r.mem_w = mw;  r.bhw = b;  r.imm = im;  r.index = ix;
      r.rs1_rdy = 1'b1; r.rs1_tag = '0; r.rs1_data = r1; r.exp_rs1 = r1;
      r.rs2_rdy = 1'b1; r.rs2_tag = '0; r.rs2_data = r2; r.exp_rs2 = r2;
      return r;
   endfunction

   task automatic drive(input op_t p);
      bus.iss_valid    = 1'b1;
      bus.iss_mem_w    = p.mem_w;
      bus.iss_bhw      = p.bhw;
      bus.iss_imm      = p.imm;
      bus.iss_rs1_rdy  = p.rs1_rdy;
      bus.iss_rs1_tag  = p.rs1_tag;
      bus.iss_rs1_data = p.rs1_data;
      bus.iss_rs2_rdy  = p.rs2_rdy;
      bus.iss_rs2_tag  = p.rs2_tag;
      bus.iss_rs2_data = p.rs2_data;
      bus.iss_index    = p.index;
   endtask

   // Drive for one edge; push to the scoreboard when the op must be accepted.
   task automatic dispatch(input op_t p, input bit push);
      drive(p);
      tick();
      bus.iss_valid = 1'b0;
      if (push) sb.push_back(p);
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      chk("drain_remaining", 32'(sb.size()), 32'd0);
   endtask

   // Scoreboard monitor: every issue must match the oldest accepted op.
   always @(negedge clk) begin
      if (!rst && bus.fu_en === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue actual_index=%0d required=no_issue",
                     bus.fu_index);
         end else begin
            mon_e = sb.pop_front();
            chk("fu_index",    32'(bus.fu_index), 32'(mon_e.index));
            chk("fu_mem_w",    32'(bus.fu_mem_w), 32'(mon_e.mem_w));
            chk("fu_bhw",      32'(bus.fu_bhw),   32'(mon_e.bhw));
            chk("fu_imm",      bus.fu_imm,        mon_e.imm);
            chk("fu_rs1_data", bus.fu_rs1_data,   mon_e.exp_rs1);
            chk("fu_rs2_data", bus.fu_rs2_data,   mon_e.exp_rs2);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.iss_valid = 1'b0;  bus.iss_mem_w = 1'b0;  bus.iss_bhw = '0;
      bus.iss_imm = '0;      bus.iss_rs1_rdy = 1'b0; bus.iss_rs2_rdy = 1'b0;
      bus.iss_rs1_tag = '0;  bus.iss_rs2_tag = '0;  bus.iss_rs1_data = '0;
      bus.iss_rs2_data = '0; bus.iss_index = '0;    bus.cdb_valid = 1'b0;
      bus.cdb_tag = '0;      bus.cdb_data = '0;     bus.fu_idle = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_full",        32'(bus.full),  32'd0);
      chk("rst_fu_en",       32'(bus.fu_en), 32'd0);
      chk("rst_fu_rs1_data", bus.fu_rs1_data, 32'd0);
      chk("rst_fu_rs2_data", bus.fu_rs2_data, 32'd0);
      chk("rst_fu_imm",      bus.fu_imm,      32'd0);
      chk("rst_fu_index",    32'(bus.fu_index), 32'd0);
      rst = 1'b0;
      tick();

      // Table: ready ops into an empty buffer, FU idle
      vec[0] = mk(1'b0, 3'b010, 32'd4,          32'h0000_0100, 32'h0,          4'd0);
      vec[1] = mk(1'b1, 3'b000, 32'd0,          32'h0000_2000, 32'h0000_00A5, 4'd1);
      vec[2] = mk(1'b1, 3'b001, 32'hFFFF_FFFC,  32'h8000_0000, 32'h0000_1234, 4'd2);
      vec[3] = mk(1'b0, 3'b100, 32'h7FFF_FFFF,  32'hFFFF_FFFF, 32'h0,          4'd15);
      vec[4] = mk(1'b1, 3'b010, 32'd8,          32'h0000_0010, 32'hFFFF_FFFF, 4'd7);
      vec[5] = mk(1'b0, 3'b101, 32'd2,          32'h0,          32'h0,          4'd3);
      bus.fu_idle = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(vec[i]);
         chk("no_issue_on_enqueue", 32'(bus.fu_en), 32'd0);
         tick();
         bus.iss_valid = 1'b0;
         sb.push_back(vec[i]);
         chk("issue_next_cycle", 32'(bus.fu_en), 32'd1);
         tick();
         chk("empty_after_issue", 32'(bus.fu_en), 32'd0);
      end
      wait_drain(10);

      // Store whose rs2 is woken by the CDB
      o = mk(1'b1, 3'b010, 32'h40, 32'h20, 32'h0, 4'd6);
      o.rs2_rdy = 1'b0; o.rs2_tag = 4'd3; o.rs2_data = 32'h0;
      o.exp_rs2 = 32'hDEAD_BEEF;
      dispatch(o, 1'b1);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd3; bus.cdb_data = 32'hDEAD_BEEF;
      chk("store_waits_rs2", 32'(bus.fu_en), 32'd0);
      tick();
      bus.cdb_valid = 1'b0;
      chk("store_wakeup_issue", 32'(bus.fu_en), 32'd1);
      wait_drain(10);

      // Fill with FU busy, ignore a dispatch while full, drain in order
      bus.fu_idle = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) chk("not_full_at_3", 32'(bus.full), 32'd0);
         dispatch(mk(1'b0, 3'b010, 32'(16 * i), 32'(i + 1), 32'h0, 4'(i)), 1'b1);
      end
      chk("full_at_4", 32'(bus.full), 32'd1);
      dispatch(mk(1'b1, 3'b000, 32'hBAD, 32'hBAD, 32'hBAD, 4'd9), 1'b0);
      chk("full_after_ignored", 32'(bus.full),  32'd1);
      chk("busy_fu_no_issue",   32'(bus.fu_en), 32'd0);
      bus.fu_idle = 1'b1;
      wait_drain(20);
      chk("drained_fu_en", 32'(bus.fu_en), 32'd0);
      chk("drained_full",  32'(bus.full),  32'd0);

      // Head blocked on tag 5 while the younger entry is ready
      o = mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd1);
      o.rs1_rdy = 1'b0; o.rs1_tag = 4'd5; o.exp_rs1 = 32'h77;
      dispatch(o, 1'b1);
      dispatch(mk(1'b0, 3'b010, 32'h14, 32'h300, 32'h0, 4'd2), 1'b1);
      chk("head_blocked_a", 32'(bus.fu_en), 32'd0);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd6; bus.cdb_data = 32'h99;
      tick();
      chk("head_blocked_b", 32'(bus.fu_en), 32'd0);
      bus.cdb_tag = 4'd5; bus.cdb_data = 32'h77;
      chk("head_blocked_c", 32'(bus.fu_en), 32'd0);
      tick();
      bus.cdb_valid = 1'b0;
      chk("head_woken_issue", 32'(bus.fu_en),    32'd1);
      chk("head_woken_index", 32'(bus.fu_index), 32'd1);
      wait_drain(10);

      // Dispatch bypass: CDB broadcasts the missing tag on the entry edge
      o = mk(1'b1, 3'b001, 32'h8, 32'h1234, 32'h66, 4'd4);
      o.rs1_rdy = 1'b0; o.rs1_tag = 4'd7; o.exp_rs1 = 32'h55;
      drive(o);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd7; bus.cdb_data = 32'h55;
      tick();
      bus.iss_valid = 1'b0; bus.cdb_valid = 1'b0;
      sb.push_back(o);
      chk("bypass_issue",    32'(bus.fu_en), 32'd1);
      chk("bypass_rs1_data", bus.fu_rs1_data, 32'h55);
      wait_drain(10);

      // Reset with live entries overrides enqueue and CDB capture
      bus.fu_idle = 1'b0;
      for (int i = 0; i < 3; i++)
         dispatch(mk(1'b0, 3'b010, 32'h0, 32'hA0 + 32'(i), 32'h0, 4'(10 + i)), 1'b1);
      rst = 1'b1;
      bus.fu_idle = 1'b1;
      drive(mk(1'b1, 3'b010, 32'h4, 32'h1, 32'h2, 4'd14));
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd2; bus.cdb_data = 32'h1;
      tick();
      rst = 1'b0; bus.iss_valid = 1'b0; bus.cdb_valid = 1'b0;
      sb.delete();
      chk("rst2_full",        32'(bus.full),     32'd0);
      chk("rst2_fu_en",       32'(bus.fu_en),    32'd0);
      chk("rst2_fu_rs1_data", bus.fu_rs1_data,   32'd0);
      chk("rst2_fu_imm",      bus.fu_imm,        32'd0);
      chk("rst2_fu_index",    32'(bus.fu_index), 32'd0);
      chk("rst2_fu_mem_w",    32'(bus.fu_mem_w), 32'd0);

      // Six back-to-back ops: enqueue and dequeue together, pointers wrap
      for (int i = 0; i < 6; i++)
         dispatch(mk(1'(i % 2), 3'(i), 32'(4 * i), 32'h1000 + 32'(i),
                     32'h2000 + 32'(i), 4'(8 + i)), 1'b1);
      chk("stream_not_full", 32'(bus.full),  32'd0);
      chk("stream_last_en",  32'(bus.fu_en), 32'd1);
      wait_drain(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
